// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding, lane slicing and byte-enable helpers for prog_loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [3:0] BE_FULL = 4'b1111;

    // First stream byte of a word lands in the most significant lane, as fetch expects.
    localparam logic [4:0] LANE0_LSB = 5'd24;
    localparam logic [4:0] LANE1_LSB = 5'd16;
    localparam logic [4:0] LANE2_LSB = 5'd8;
    localparam logic [4:0] LANE3_LSB = 5'd0;

    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
        case (lane)
            2'd0:    return LANE0_LSB;
            2'd1:    return LANE1_LSB;
            2'd2:    return LANE2_LSB;
            default: return LANE3_LSB;
        endcase
    endfunction

    function automatic logic [3:0] filled_be(input logic [1:0] lanes_filled);
        case (lanes_filled)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b1000;
            2'd2:    return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte stream, instruction-memory write port and load status bundle
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_be,
        input  cpu_hold, load_done, load_err, word_count
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_be,
        output cpu_hold, load_done, load_err, word_count
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// rtl/prog_loader_byte_packer.sv - lane counter, pack register and partial-word zero-fill
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic        flush,
    input  logic [7:0]  data,
    output logic [1:0]  lane,
    output logic [31:0] full_word,
    output logic [31:0] flush_word,
    output logic [3:0]  flush_be
);
    logic [31:0] pack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= 2'd0;
            pack <= '0;
        end else if (clear) begin
            lane <= 2'd0;
            pack <= '0;
        end else if (push) begin
            pack[lane_lsb(lane) +: 8] <= data;
            lane <= lane + 2'd1;
        end else if (flush) begin
            lane <= 2'd0;
        end
    end

    // The completing byte bypasses the pack register so the word is written the cycle after.
    assign full_word  = {pack[31:8], data};
    assign flush_be   = filled_be(lane);
    assign flush_word = pack & be_mask(flush_be);
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - packs a host byte stream into instruction-memory words and holds the core in reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic        clk,
    input  logic        reset,
    prog_loader_if.slave bus
);
    localparam logic [ADDR_W:0] WC_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic              in_ready;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [ADDR_W:0]   word_count;

    logic [1:0]        lane;
    logic [31:0]       full_word;
    logic [31:0]       flush_word;
    logic [3:0]        flush_be;

    logic accept;
    logic full;
    logic store;
    logic word_done;

    // Start outranks a byte presented in the same cycle.
    assign accept    = bus.in_valid & in_ready & ~bus.start;
    assign full      = (word_count == WC_DEPTH);
    assign store     = accept & ~full;
    assign word_done = store & (lane == 2'd3);

    prog_loader_byte_packer u_byte_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.start),
        .push       (store),
        .flush      (state == FLUSH),
        .data       (bus.in_data),
        .lane       (lane),
        .full_word  (full_word),
        .flush_word (flush_word),
        .flush_be   (flush_be)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (bus.start) next_state = LOAD;
            LOAD: begin
                if (bus.start)          next_state = LOAD;
                else if (accept) begin
                    if (full)           next_state = ERR;
                    else if (bus.in_last) next_state = (lane == 2'd3) ? DONE : FLUSH;
                end
            end
            FLUSH:   next_state = bus.start ? LOAD : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cpu_hold  = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            LOAD: in_ready = 1'b1;
            DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            ERR:  load_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (bus.start) begin
                mem_addr   <= '0;
                word_count <= '0;
            end else if (state == LOAD && word_done) begin
                mem_we     <= 1'b1;
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= full_word;
                mem_be     <= BE_FULL;
                word_count <= word_count + (ADDR_W+1)'(1);
            end else if (state == FLUSH) begin
                mem_we     <= 1'b1;
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= flush_word;
                mem_be     <= flush_be;
                word_count <= word_count + (ADDR_W+1)'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.load_done  = load_done;
    assign bus.load_err   = load_err;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_be     = mem_be;
    assign bus.word_count = word_count;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader (DEPTH 256 and DEPTH 2 instances)
module tb_prog_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       sel;
    logic       start_s;
    logic       valid_s;
    logic       last_s;
    logic [7:0] data_s;

    prog_loader_if #(.ADDR_W(8)) big_if ();
    prog_loader_if #(.ADDR_W(1)) small_if ();

    prog_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (big_if.slave)
    );

    prog_loader #(.ADDR_W(1), .DEPTH(2)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (small_if.slave)
    );

    assign big_if.start      = start_s & ~sel;
    assign big_if.in_valid   = valid_s & ~sel;
    assign big_if.in_data    = data_s;
    assign big_if.in_last    = last_s;
    assign small_if.start    = start_s & sel;
    assign small_if.in_valid = valid_s & sel;
    assign small_if.in_data  = data_s;
    assign small_if.in_last  = last_s;

    logic       cur_ready, cur_done, cur_err, cur_hold;
    logic [8:0] cur_wc;
    assign cur_ready = sel ? small_if.in_ready  : big_if.in_ready;
    assign cur_done  = sel ? small_if.load_done : big_if.load_done;
    assign cur_err   = sel ? small_if.load_err  : big_if.load_err;
    assign cur_hold  = sel ? small_if.cpu_hold  : big_if.cpu_hold;
    assign cur_wc    = sel ? {7'b0, small_if.word_count} : big_if.word_count;

    wr_t exp_big[$];
    wr_t exp_small[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t wb;
        if (!reset && big_if.mem_we === 1'b1) begin
            if (exp_big.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL big_unexpected_write: got addr %0d data %h, expected none",
                         big_if.mem_addr, big_if.mem_wdata);
            end else begin
                wb = exp_big.pop_front();
                check("big_addr", 32'(big_if.mem_addr), 32'(wb.addr));
                check("big_wdata", big_if.mem_wdata, wb.data);
                check("big_be", 32'(big_if.mem_be), 32'(wb.be));
            end
        end
        if (!reset && small_if.mem_we === 1'b1) begin
            if (exp_small.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL small_unexpected_write: got addr %0d data %h, expected none",
                         small_if.mem_addr, small_if.mem_wdata);
            end else begin
                wb = exp_small.pop_front();
                check("small_addr", 32'(small_if.mem_addr), 32'(wb.addr));
                check("small_wdata", small_if.mem_wdata, wb.data);
                check("small_be", 32'(small_if.mem_be), 32'(wb.be));
            end
        end
    end

    // Reference: split the image into 4-byte words, cap at depth, pad a trailing partial word.
    task automatic model(input logic [7:0] img[$], input bit last, input int depth,
                         input bit record, output int lat, output bit done,
                         output bit err, output int wc);
        int  n;
        int  words;
        int  rem;
        wr_t w;
        n     = img.size();
        err   = (n > 4 * depth);
        words = err ? depth : n / 4;
        rem   = n % 4;
        for (int i = 0; i < words; i++) begin
            w.addr = i;
            w.data = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
            w.be   = 4'hF;
            if (record) begin
                if (sel) exp_small.push_back(w);
                else     exp_big.push_back(w);
            end
        end
        done = !err && last;
        wc   = words;
        lat  = 1;
        if (done && rem != 0) begin
            w.addr = words;
            w.data = '0;
            w.be   = '0;
            for (int b = 0; b < rem; b++) begin
                w.data = w.data | (32'(img[4*words+b]) << (24 - 8 * b));
                w.be[3-b] = 1'b1;
            end
            if (record) begin
                if (sel) exp_small.push_back(w);
                else     exp_big.push_back(w);
            end
            wc  = words + 1;
            lat = 2;
        end
    endtask

    task automatic send(input logic [7:0] img[$], input bit last);
        int gap;
        int k;
        @(posedge clk); #1;
        start_s = 1'b1;
        valid_s = 1'($urandom_range(0, 1));
        data_s  = 8'($urandom);
        last_s  = 1'b0;
        @(posedge clk); #1;
        start_s = 1'b0;
        valid_s = 1'b0;
        for (int i = 0; i < img.size(); i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            k = 0;
            while (!cur_ready && k < 20) begin @(posedge clk); #1; k++; end
            if (!cur_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: got in_ready 0 at byte %0d, expected 1", i);
                return;
            end
            valid_s = 1'b1;
            data_s  = img[i];
            last_s  = last && (i == img.size() - 1);
            @(posedge clk); #1;
            valid_s = 1'b0;
            last_s  = 1'b0;
        end
    endtask

    task automatic run_image(input logic [7:0] img[$], input bit last, input int depth);
        int lat, wc, k;
        bit done, err;
        model(img, last, depth, 1'b1, lat, done, err, wc);
        send(img, last);
        if (done || err) begin
            k = 0;
            do begin @(negedge clk); k++; end while (!(cur_done || cur_err) && k < 6);
            check("status_latency", 32'(k), 32'(lat));
        end else begin
            @(negedge clk);
            @(negedge clk);
        end
        check("load_done", 32'(cur_done), 32'(done));
        check("load_err", 32'(cur_err), 32'(err));
        check("cpu_hold", 32'(cur_hold), 32'(!done));
        check("in_ready", 32'(cur_ready), 32'(!done && !err));
        check("word_count", 32'(cur_wc), 32'(wc));
        @(negedge clk);
        @(negedge clk);
        check("writes_drained", 32'(sel ? exp_small.size() : exp_big.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] img[$];
        int lat, wc, n;
        bit done, err;

        reset   = 1'b1;
        sel     = 1'b0;
        start_s = 1'b0;
        valid_s = 1'b0;
        last_s  = 1'b0;
        data_s  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("idle_cpu_hold", 32'(big_if.cpu_hold), 32'd1);
            check("idle_in_ready", 32'(big_if.in_ready), 32'd0);
            check("idle_outputs", {big_if.mem_wdata}, 32'd0);
            check("idle_misc", {20'd0, big_if.word_count, big_if.mem_addr, big_if.mem_be,
                   big_if.load_done, big_if.load_err, big_if.mem_we}, 32'd0);
            check("small_idle_hold", 32'(small_if.cpu_hold), 32'd1);
        end

        img = '{8'h55, 8'h89, 8'hE5, 8'hB8};
        run_image(img, 1'b1, 256);
        img = '{8'h55, 8'h89, 8'hE5, 8'hB8, 8'h02, 8'h00};
        run_image(img, 1'b1, 256);

        img = '{8'h11, 8'h22, 8'h33};
        run_image(img, 1'b0, 256);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image(img, 1'b1, 256);

        repeat (24) begin
            n = $urandom_range(1, 24);
            img.delete();
            repeat (n) img.push_back(8'($urandom));
            run_image(img, $urandom_range(0, 3) != 0, 256);
        end

        sel = 1'b1;
        img.delete();
        repeat (9) img.push_back(8'($urandom));
        run_image(img, 1'b0, 2);
        img.delete();
        repeat (8) img.push_back(8'($urandom));
        run_image(img, 1'b1, 2);
        img.delete();
        repeat (9) img.push_back(8'($urandom));
        run_image(img, 1'b1, 2);
        repeat (6) begin
            n = $urandom_range(1, 9);
            img.delete();
            repeat (n) img.push_back(8'($urandom));
            run_image(img, 1'b1, 2);
        end

        sel = 1'b0;
        img.delete();
        repeat (4) img.push_back(8'($urandom));
        model(img, 1'b0, 256, 1'b0, lat, done, err, wc);
        send(img, 1'b0);
        check("rst_window_we", 32'(big_if.mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_we_dropped", 32'(big_if.mem_we), 32'd0);
        check("rst_cpu_hold", 32'(big_if.cpu_hold), 32'd1);
        check("rst_in_ready", 32'(big_if.in_ready), 32'd0);
        check("rst_word_count", 32'(big_if.word_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h7F};
        run_image(img, 1'b1, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
